// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//
// Shares one UART transmitter between two on-chip requesters:
//   * the register-file read path, one byte per request
//   * the ALU result path, a 2*DATA_WIDTH-bit result sent low byte first
//
// Each requester has a one-deep holding register. A round-robin arbiter picks
// the next source, and a small FSM presents each byte on the transmitter's
// parallel interface with a single-cycle valid strobe. It then follows the
// transmitter's busy flag: first waiting for busy to rise (bounded by
// TIMEOUT), then waiting for it to fall before the next byte or the next
// grant. An ALU transfer is atomic: both bytes go out back to back with no RF
// byte in between.
//
// Parameters:
//   DATA_WIDTH  UART frame payload width in bits
//   TIMEOUT     cycles allowed for tx_busy to rise after a byte is issued
//               (1..255)
//
// Ports:
//   clk          system reference clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   rf_data      register-file read data
//   rf_valid     rf_data valid, captured while rf_ready=1
//   rf_ready     RF holding register empty
//   alu_data     ALU result (2*DATA_WIDTH bits)
//   alu_valid    alu_data valid, captured while alu_ready=1
//   alu_ready    ALU holding register empty
//   tx_busy      transmitter busy flag, already synchronised to clk
//   tx_data      byte driven to the transmitter's parallel data input
//   tx_valid     one-cycle data-valid strobe to the transmitter
//   sched_busy   scheduler FSM is not idle
//   timeout_err  one-cycle pulse: the transmitter never went busy
// ---------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 63
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     rf_data,
    input  logic                      rf_valid,
    output logic                      rf_ready,
    input  logic [2*DATA_WIDTH-1:0]   alu_data,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic                      tx_busy,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    output logic                      sched_busy,
    output logic                      timeout_err
);

    // The wait counter holds 0..TIMEOUT-1. The timeout fires before it could
    // wrap, so this width is always enough.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t                    state;
    logic                      rf_pend;
    logic                      alu_pend;
    logic [DATA_WIDTH-1:0]     rf_hold;
    logic [2*DATA_WIDTH-1:0]   alu_hold;
    logic                      grant_alu;   // source of the transfer in flight
    logic                      tie_alu;     // ALU wins the next contested grant
    logic                      byte_idx;    // ALU byte in flight: 0 low, 1 high
    logic [CNT_W-1:0]          cnt;

    logic                      rf_cap;
    logic                      alu_cap;
    logic                      pick_alu;
    logic                      tie;

    assign rf_ready   = ~rf_pend;
    assign alu_ready  = ~alu_pend;
    assign sched_busy = (state != IDLE);

    assign rf_cap  = rf_valid  & ~rf_pend;
    assign alu_cap = alu_valid & ~alu_pend;

    // The arbiter looks only at the registered pending flags. A request
    // captured on this edge competes from the next cycle onwards.
    assign tie      = rf_pend & alu_pend;
    assign pick_alu = alu_pend & (~rf_pend | tie_alu);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rf_pend     <= 1'b0;
            alu_pend    <= 1'b0;
            rf_hold     <= '0;
            alu_hold    <= '0;
            grant_alu   <= 1'b0;
            tie_alu     <= 1'b0;
            byte_idx    <= 1'b0;
            cnt         <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_valid    <= 1'b0;
            timeout_err <= 1'b0;

            // Capture into the holding registers. A source is only ever
            // cleared below while its pend is set, so a capture and a clear
            // never hit the same source on the same edge.
            if (rf_cap) begin
                rf_hold <= rf_data;
                rf_pend <= 1'b1;
            end
            if (alu_cap) begin
                alu_hold <= alu_data;
                alu_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // A busy transmitter here belongs to someone else, so
                    // wait for it to go idle. No timeout applies in IDLE.
                    if (!tx_busy && (rf_pend || alu_pend)) begin
                        grant_alu <= pick_alu;
                        byte_idx  <= 1'b0;
                        tx_data   <= pick_alu ? alu_hold[DATA_WIDTH-1:0] : rf_hold;
                        tx_valid  <= 1'b1;
                        // The round-robin pointer moves only when both
                        // sources competed. Afterwards the loser of this
                        // tie wins the next one.
                        if (tie) begin
                            tie_alu <= ~pick_alu;
                        end
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // The transmitter never accepted the byte. Drop the
                        // whole request, including any unsent ALU high byte.
                        timeout_err <= 1'b1;
                        if (grant_alu) begin
                            alu_pend <= 1'b0;
                        end else begin
                            rf_pend <= 1'b0;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (grant_alu && !byte_idx) begin
                            // Send the high byte straight away so that an RF
                            // request cannot slip between the two halves.
                            tx_data  <= alu_hold[2*DATA_WIDTH-1:DATA_WIDTH];
                            byte_idx <= 1'b1;
                            tx_valid <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            if (grant_alu) begin
                                alu_pend <= 1'b0;
                            end else begin
                                rf_pend <= 1'b0;
                            end
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Bench for uart_tx_sched. A behavioural transmitter raises tx_busy two
// cycles after each tx_valid and holds it for ten cycles. The stimulus
// pushes the expected byte sequence into a queue. A separate monitor pops
// that queue on every tx_valid and compares the popped byte with tx_data.
// All sampling and driving happens on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int DW = 8;
    localparam int TO = 63;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   rf_data;
    logic            rf_valid;
    logic            rf_ready;
    logic [2*DW-1:0] alu_data;
    logic            alu_valid;
    logic            alu_ready;
    logic            tx_busy;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            sched_busy;
    logic            timeout_err;

    logic            model_busy;
    logic            force_busy;
    logic            model_en;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txv  = 0;
    int n_to   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    assign tx_busy = model_busy | force_busy;

    uart_tx_sched #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rf_data    (rf_data),
        .rf_valid   (rf_valid),
        .rf_ready   (rf_ready),
        .alu_data   (alu_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .sched_busy (sched_busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural UART transmitter: busy rises 2 cycles after tx_valid and
    // stays high for 10 cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && tx_valid === 1'b1) begin
                repeat (2) @(negedge clk);
                model_busy = 1'b1;
                repeat (10) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: every tx_valid must match the oldest expected byte.
    initial begin
        logic [DW-1:0] exp_byte;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                n_txv++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_data unexpected: got 0x%0h, no byte expected", tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("tx_data", {24'd0, tx_data}, {24'd0, exp_byte});
                end
            end
            if (timeout_err === 1'b1) n_to++;
        end
    end

    task automatic wait_txv(input string name, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx_valid !== 1'b1 && k < 300);
        if (tx_valid !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no tx_valid within %0d cycles", name, k);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rf_ready && alu_ready && !sched_busy && !tx_busy) && k < 500);
        if (!(rf_ready && alu_ready && !sched_busy && !tx_busy)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scheduler not idle after %0d cycles", name, k);
        end
    endtask

    task automatic send_alu(input logic [2*DW-1:0] d);
        @(negedge clk);
        alu_data  = d;
        alu_valid = 1'b1;
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d compared)", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int base;
        int base_to;

        rst_n      = 1'b0;
        rf_valid   = 1'b1;
        rf_data    = 8'h77;
        alu_valid  = 1'b0;
        alu_data   = '0;
        force_busy = 1'b0;
        model_en   = 1'b1;

        // 1: reset while rf_valid is held high
        repeat (3) @(negedge clk);
        check("reset tx_valid",    tx_valid,    0);
        check("reset tx_data",     tx_data,     0);
        check("reset timeout_err", timeout_err, 0);
        check("reset sched_busy",  sched_busy,  0);
        check("reset rf_ready",    rf_ready,    1);
        check("reset alu_ready",   alu_ready,   1);
        rst_n    = 1'b1;
        rf_valid = 1'b0;
        @(negedge clk);
        check("rf_ready after release",   rf_ready,   1);
        check("sched_busy after release", sched_busy, 0);

        // 2: single RF byte; tx_valid appears in the cycle after the grant edge
        @(negedge clk);
        rf_data  = 8'hA5;
        rf_valid = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        rf_valid = 1'b0;
        check("rf_ready after capture", rf_ready, 0);
        check("tx_valid before grant",  tx_valid, 0);
        @(negedge clk);
        check("rf tx_valid latency", tx_valid, 1);
        repeat (12) @(negedge clk);
        check("rf_ready while busy high", rf_ready, 0);
        @(negedge clk);
        check("rf_ready after busy falls", rf_ready, 1);
        wait_idle("rf single");
        check("rf single pulse count", n_txv, 1);

        // 3: ALU result, low byte then high byte after busy falls
        base = n_txv;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        send_alu(16'h1234);
        wait_txv("alu low byte", k);
        check("alu low byte latency", k, 1);
        wait_txv("alu high byte", k);
        check("alu high byte gap", k, 13);
        repeat (12) @(negedge clk);
        check("alu_ready before second byte done", alu_ready, 0);
        @(negedge clk);
        check("alu_ready after second byte", alu_ready, 1);
        wait_idle("alu");
        check("alu pulse count", n_txv - base, 2);

        // 4: both requesters on the same edge, twice; ties alternate
        base = n_txv;
        @(negedge clk);
        rf_data   = 8'h11;
        alu_data  = 16'hBEEF;
        rf_valid  = 1'b1;
        alu_valid = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        @(negedge clk);
        rf_valid  = 1'b0;
        alu_valid = 1'b0;
        wait_idle("tie round 1");
        check("tie round 1 queue drained", exp_q.size(), 0);
        @(negedge clk);
        rf_valid  = 1'b1;
        alu_valid = 1'b1;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'h11);
        @(negedge clk);
        rf_valid  = 1'b0;
        alu_valid = 1'b0;
        wait_idle("tie round 2");
        check("tie pulse count", n_txv - base, 6);

        // 5: transmitter never goes busy. ISSUE is followed by TIMEOUT cycles
        // in WAIT_HI, and the registered pulse is seen one cycle later.
        model_en = 1'b0;
        base     = n_txv;
        base_to  = n_to;
        exp_q.push_back(8'hFE);
        send_alu(16'hCAFE);
        wait_txv("timeout low byte", k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (timeout_err !== 1'b1 && k < 200);
        check("timeout delay", k, TO + 1);
        check("alu_ready at timeout",  alu_ready,  1);
        check("sched_busy at timeout", sched_busy, 0);
        @(negedge clk);
        check("timeout_err single cycle", timeout_err, 0);
        repeat (30) @(negedge clk);
        check("timeout pulse count",     n_to - base_to, 1);
        check("no high byte after timeout", n_txv - base, 1);
        model_en = 1'b1;

        // 6a: foreign busy in IDLE stalls the grant
        @(negedge clk);
        force_busy = 1'b1;
        rf_data    = 8'h5A;
        rf_valid   = 1'b1;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        rf_valid = 1'b0;
        base     = n_txv;
        repeat (20) @(negedge clk);
        check("no tx_valid while busy", n_txv - base, 0);
        check("idle while busy",       sched_busy,   0);
        check("rf still pending",      rf_ready,     0);
        force_busy = 1'b0;
        wait_txv("grant after busy drops", k);
        check("grant after busy drops latency", k, 1);
        wait_idle("stall");

        // 6b: reset during the ALU WAIT_LO drops the high byte
        exp_q.push_back(8'h88);
        send_alu(16'h7788);
        wait_txv("reset low byte", k);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset sched_busy", sched_busy, 0);
        check("mid reset rf_ready",   rf_ready,   1);
        check("mid reset alu_ready",  alu_ready,  1);
        check("mid reset tx_valid",   tx_valid,   0);
        rst_n = 1'b1;
        base  = n_txv;
        repeat (40) @(negedge clk);
        check("no high byte after reset", n_txv - base, 0);

        check("final queue drained", exp_q.size(), 0);
        check("total tx_valid",      n_txv,        12);
        check("total timeout pulses", n_to,        1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
